// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder:
// access sizes, FSM states, byte-lane mask and access-error decode.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Little-endian byte enables for an access of the given size at addr[1:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && addr_lo[0]) ||
               (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extender.sv
// Selects the addressed byte/half/word lanes of a memory word and sign- or zero-extends.
// Combinational, no latency; no flow control.
module data_mem_responder_load_extender
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the core's load/store port: one request at a time on a byte-lane word array.
// Latency: response LATENCY+1 cycles after request handshake; at least one idle cycle between transactions.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = DEPTH_LOG2 + 2;

    state_t state, state_nxt;
    logic [3:0]    cnt;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0] mem [2**DEPTH_LOG2];

    logic          accept;
    logic          do_access;
    logic          acc_we;
    logic [1:0]    acc_size;
    logic          acc_uns;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [3:0]    acc_mask;
    logic [31:0]   acc_wrep;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;
    logic          unused_addr_hi;

    // Upper address bits alias onto the array.
    assign unused_addr_hi = ^req_addr[31:AW];

    assign accept = (state == ST_IDLE) && req_valid;

    // With zero latency the access happens on the accept edge, straight from the request inputs.
    assign do_access = (state == ST_ACCESS && cnt <= 4'd1) || (accept && (LATENCY == 0));

    assign acc_we    = (state == ST_IDLE) ? req_we             : we_q;
    assign acc_size  = (state == ST_IDLE) ? req_size           : size_q;
    assign acc_uns   = (state == ST_IDLE) ? req_unsigned       : uns_q;
    assign acc_addr  = (state == ST_IDLE) ? req_addr[AW-1:0]   : addr_q;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata          : wdata_q;

    assign acc_err  = access_err(acc_size, acc_addr[1:0]);
    assign acc_mask = lane_mask(acc_size, acc_addr[1:0]);
    assign acc_wrep = (acc_size == SZ_BYTE) ? {4{acc_wdata[7:0]}}  :
                      (acc_size == SZ_HALF) ? {2{acc_wdata[15:0]}} : acc_wdata;
    assign rd_word  = mem[acc_addr[AW-1:2]];

    data_mem_responder_load_extender u_ext (
        .word        (rd_word),
        .addr_lo     (acc_addr[1:0]),
        .size        (acc_size),
        .is_unsigned (acc_uns),
        .data        (ld_data)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (LATENCY == 0) ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt <= 4'd1) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY);
            end else if (state == ST_ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= (acc_err || acc_we) ? 32'd0 : ld_data;
                rsp_err   <= acc_err;
            end else if (rsp_valid && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; a reset in flight suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) mem[acc_addr[AW-1:2]][8*i +: 8] <= acc_wrep[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the core's data-memory load/store interface.
- Accepts one request at a time: address, size, write enable, write data.
- Performs a byte-lane access on an internal word array after a configurable wait, then returns load data (sign/zero-extended) or a store acknowledge through a valid/ready response handshake.
- Sits between the core's load/store path and the writeback mux input for memory data.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words in the array (1024 words = 4 KiB).
- LATENCY, 2, wait cycles spent in ACCESS (0 to 15 legal).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or reserved-size request.

Behaviour:
- Reset: state = IDLE; req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; wait counter = 0. Array contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, size, unsigned, addr, wdata.
  - Go to ACCESS with counter = LATENCY. If LATENCY = 0, go directly to RESP.
  - req_ready = 0 in all other states.
- ACCESS:
  - Counter decrements each cycle.
  - When the counter is 1, the next state is RESP.
  - The array operation happens on the ACCESS->RESP edge (the IDLE->RESP edge when LATENCY = 0).
- Array operation:
  - Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored (aliasing).
  - Byte lanes are little-endian.
  - Store byte writes lane addr[1:0]. Store half writes lanes {addr[1],0} and {addr[1],1}. Store word writes all lanes. Unwritten lanes keep their value.
  - Load selects the same lanes and extends to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Error conditions: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - On error: no array write, rsp_rdata = 0, rsp_err = 1.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and req_ready = 1 the next cycle.
- Throughput: minimum request-to-response latency is LATENCY+1 cycles. Back-to-back issue is not possible; at least one IDLE cycle separates transactions.
- rsp_ready outside RESP is ignored. req_valid outside IDLE is ignored and not queued.
- Reset mid-operation: a store still in ACCESS is discarded (no write). A store already in RESP has committed. After reset, state = IDLE.
- Read-after-write: a load issued after a store's response is accepted returns the stored data.

Decomposition:
- Shared package (e.g. mem_pkg) holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state constants.
  - A lane-mask function: size plus addr[1:0] gives a 4-bit byte enable.
- One natural sub-module, load_extender (combinational): word, addr[1:0], size and unsigned in; extended 32-bit load value out.
- The FSM and array remain in data_mem_responder.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10 and load word at 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly LATENCY+1 cycles after acceptance.
- After the previous test, store byte 0x7F at 0x13, then load word at 0x10 -> 0x7FADBEEF. Load byte signed at 0x11 -> 0xFFFFFFBE. Load byte unsigned at 0x11 -> 0x000000BE.
- Store half 0x8001 at 0x22, then load half signed at 0x22 -> 0xFFFF8001 and load half unsigned -> 0x00008001. Then store half at 0x21 -> rsp_err = 1, rsp_rdata = 0, and a word load at 0x20 shows lanes unchanged.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready = 0. With req_valid asserted meanwhile, no second request is accepted.
- Start a store of 0x12345678 to 0x40 and assert rst during ACCESS -> outputs return to reset values; a later word load at 0x40 returns the prior contents.
- With LATENCY = 0, store then load at address 0x1004 (aliasing word index 1 when DEPTH_LOG2 = 10) -> a load at 0x4 returns the same data; response arrives 1 cycle after acceptance.
